apb_master_fsm: RTL and testbench
=================================

# apb_master_fsm

APB requester stage that sits directly downstream of the interconnect's request FIFO. It pops one queued command at a time from the FIFO's show-ahead read port and runs a complete APB3 SETUP/ACCESS transfer on the slave-side bus. It then returns the read data and error status on a valid/ready response port. Transfers are strictly one at a time, with no overlap.

## Interface
Parameters:
- ADDR_WIDTH, 32, PADDR width.
- DATA_WIDTH, 32, PWDATA/PRDATA width.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles before abort. Used only when the timeout feature is compiled in; must be ≥ 2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fifo_rd_data  in  ADDR_WIDTH+DATA_WIDTH+1  head entry, show-ahead. Bit [MSB] is write (1 = write); next ADDR_WIDTH bits are addr; low DATA_WIDTH bits are wdata.
- fifo_empty  in  1  FIFO has no entry.
- fifo_rd_en  out  1  pop strobe; combinational.
- paddr  out  ADDR_WIDTH  APB address.
- pwrite  out  1  APB direction.
- pwdata  out  DATA_WIDTH  APB write data.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pready  in  1  slave ready.
- prdata  in  DATA_WIDTH  slave read data.
- pslverr  in  1  slave error.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumer accepts.
- rsp_rdata  out  DATA_WIDTH  captured PRDATA for reads; 0 for writes or timeouts.
- rsp_err  out  1  PSLVERR captured, or timeout.

## Operation
States are IDLE, SETUP, ACCESS and RESP.

- **Pop rule.** fifo_rd_en = !fifo_empty && (state==IDLE || (state==RESP && rsp_ready)).
  - On that edge, write, addr and wdata are latched into command registers.
  - Next state is SETUP.
- **IDLE.** psel=0, penable=0. Stays in IDLE while fifo_empty.
- **SETUP.** psel=1, penable=0; paddr, pwrite and pwdata come from the command registers. Always moves to ACCESS after one cycle.
- **ACCESS.** psel=1, penable=1; address and data are held stable.
  - When pready=1: prdata is captured (zeroed if write) into rsp_rdata, pslverr into rsp_err, and the state moves to RESP.
  - When pready=0: the block stays in ACCESS.
- **RESP.** psel=0, penable=0, rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready.
  - On rsp_ready, the next state is SETUP if a pop occurs in the same cycle, otherwise IDLE.
  - rsp_valid never drops without rsp_ready.
- **Boundary conditions.**
  - pready, prdata and pslverr are ignored outside ACCESS.
  - fifo_empty is sampled only in IDLE, or in RESP with rsp_ready.
  - A new entry arriving while busy is not popped until the current response has been accepted.
  - paddr, pwrite and pwdata keep their last values in IDLE and RESP; they are not required to be zero.

## Timing
- **Reset.** Asynchronous assertion forces:
  - state=IDLE;
  - psel, penable, pwrite, rsp_valid, rsp_err = 0;
  - paddr, pwdata, rsp_rdata = 0;
  - fifo_rd_en=0 while rst_n=0.
- **Reset mid-transfer.** Reset during SETUP, ACCESS or RESP aborts immediately with no response; the already-popped entry is lost.
- **Latency, zero wait states, FIFO non-empty at cycle 0:**
  - cycle 0: pop;
  - cycle 1: SETUP;
  - cycle 2: ACCESS, pready=1;
  - cycle 3: rsp_valid=1.
- **Wait states.** Each pready=0 cycle adds one cycle.
- **Back-to-back.** With rsp_ready=1 and a non-empty FIFO in RESP, the next SETUP follows in the next cycle, giving a 3-cycle issue interval.

## Configuration
- APB_MASTER_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on SETUP and increments each ACCESS cycle with pready=0.
  - If the counter equals TIMEOUT_CYCLES-1 while pready=0, the block exits to RESP with rsp_err=1 and rsp_rdata=0.
  - Timed-out transfers have psel=0 from the next cycle.
- Undefined: no counter exists, and ACCESS waits indefinitely for pready.

## Test plan
- **Single write, no waits.** Entry {1, 0x0000_0010, 0xDEAD_BEEF}, pready=1 in ACCESS.
  - SETUP: psel=1, penable=0, paddr=0x10, pwdata=0xDEADBEEF.
  - ACCESS: penable=1.
  - Cycle 3: rsp_valid=1, rsp_rdata=0, rsp_err=0.
- **Read with 3 wait states.** Entry {0, 0x24, x}; prdata=0x1234_5678 with pslverr=1 at the 4th ACCESS cycle.
  - rsp_valid at cycle 6, rsp_rdata=0x12345678, rsp_err=1.
- **Back-to-back.** Three queued writes, rsp_ready tied 1.
  - fifo_rd_en pulses at cycles 0, 3 and 6.
  - psel is low exactly in cycles 3 and 6, and low again from cycle 9.
- **Response backpressure.** Hold rsp_ready=0 for 5 cycles in RESP with a second entry queued.
  - rsp_valid and data stay stable; no pop and no psel.
  - Pop occurs in the rsp_ready cycle.
- **Timeout (macro defined, TIMEOUT_CYCLES=4).** pready stuck 0.
  - After the 4th ACCESS cycle: RESP with rsp_err=1, rsp_rdata=0.
  - Without the macro, ACCESS persists for 100 cycles with no response.
- **Reset mid-ACCESS.** Drop rst_n asynchronously between edges.
  - psel, penable and rsp_valid go 0 immediately.
  - After release with fifo_empty=1, the block stays IDLE with no response.

Source files
------------

// File: rtl/apb_master_fsm.sv
// rtl/apb_master_fsm.sv - APB3 requester: pops one FIFO command, runs SETUP/ACCESS, returns a response.
// Optional ACCESS timeout is compiled in with `define APB_MASTER_TIMEOUT_EN.
module apb_master_fsm #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [ADDR_WIDTH+DATA_WIDTH:0] fifo_rd_data,
   input  logic                           fifo_empty,
   output logic                           fifo_rd_en,
   output logic [ADDR_WIDTH-1:0]          paddr,
   output logic                           pwrite,
   output logic [DATA_WIDTH-1:0]          pwdata,
   output logic                           psel,
   output logic                           penable,
   input  logic                           pready,
   input  logic [DATA_WIDTH-1:0]          prdata,
   input  logic                           pslverr,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic [DATA_WIDTH-1:0]          rsp_rdata,
   output logic                           rsp_err
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t state;
   state_t state_nxt;
   logic   pop;
   logic   timeout;
   logic   access_done;

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] to_cnt;

   assign timeout = (state == ACCESS) && !pready && (to_cnt == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt <= '0;
      end else if (state == SETUP) begin
         to_cnt <= '0;
      end else if (state == ACCESS && !pready) begin
         to_cnt <= to_cnt + 1'b1;
      end
   end
`else
   logic unused_timeout_cycles;
   assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
   assign timeout = 1'b0;
`endif

   assign access_done = (state == ACCESS) && (pready || timeout);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Pop is gated by rst_n so nothing is requested while reset is held.
   always_comb begin
      state_nxt  = state;
      pop        = 1'b0;
      psel       = 1'b0;
      penable    = 1'b0;
      rsp_valid  = 1'b0;
      case (state)
         IDLE: begin
            pop = rst_n && !fifo_empty;
            if (pop) state_nxt = SETUP;
         end
         SETUP: begin
            psel      = 1'b1;
            state_nxt = ACCESS;
         end
         ACCESS: begin
            psel    = 1'b1;
            penable = 1'b1;
            if (access_done) state_nxt = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               pop       = rst_n && !fifo_empty;
               state_nxt = pop ? SETUP : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      fifo_rd_en = pop;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwrite    <= 1'b0;
         paddr     <= '0;
         pwdata    <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         if (pop) begin
            {pwrite, paddr, pwdata} <= fifo_rd_data;
         end
         // A timeout exits with pready low: report an error and no data.
         if (access_done) begin
            rsp_rdata <= (pwrite || !pready) ? '0 : prdata;
            rsp_err   <= pready ? pslverr : 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_apb_master_fsm.sv
// tb/tb_apb_master_fsm.sv - self-checking bench for apb_master_fsm
// Honours APB_MASTER_TIMEOUT_EN to select the timeout or wait-forever expectation.
module tb_apb_master_fsm;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW+DW:0] fifo_rd_data = '0;
   logic          fifo_empty = 1'b1;
   logic          fifo_rd_en;
   logic [AW-1:0] paddr;
   logic          pwrite;
   logic [DW-1:0] pwdata;
   logic          psel;
   logic          penable;
   logic          pready = 1'b0;
   logic [DW-1:0] prdata = '0;
   logic          pslverr = 1'b0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;

   always #5 clk = ~clk;

   apb_master_fsm #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
      .fifo_rd_en(fifo_rd_en), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
      .psel(psel), .penable(penable), .pready(pready), .prdata(prdata), .pslverr(pslverr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      int            waits;
      logic [DW-1:0] rdata;
      logic          err;
      int            hold;
      bit            stuck;
   } txn_t;

   typedef struct {
      txn_t          t;
      logic [DW-1:0] exp_rdata;
      logic          exp_err;
      int            exp_lat;
   } vec_t;

   int checks = 0;
   int failures = 0;

   // Transaction-level model: FIFO contents, the command in flight and its timeline.
   txn_t fifo_q[$];
   txn_t cur;
   bit   busy = 1'b0;
   int   cyc = 0;
   int   pop_cyc = 0;
   int   resp_cyc = 0;
   int   hold_left = 0;
   int   first_valid = -1;
   logic [DW-1:0] got_rdata = '0;
   logic got_err = 1'b0;
   int   got_lat = -1;
   bit   rd_log[$];
   bit   psel_log[$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic refresh_fifo();
      fifo_empty   = (fifo_q.size() == 0);
      fifo_rd_data = fifo_empty ? '0 : {fifo_q[0].wr, fifo_q[0].addr, fifo_q[0].wdata};
   endtask

   function automatic txn_t mk(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                               input int waits, input logic [DW-1:0] rdata, input logic err, input int hold);
      txn_t t;
      t.wr = wr; t.addr = addr; t.wdata = wdata; t.waits = waits;
      t.rdata = rdata; t.err = err; t.hold = hold; t.stuck = 1'b0;
      return t;
   endfunction

   function automatic txn_t rand_txn();
      return mk(1'($urandom), $urandom, $urandom, int'($urandom_range(0, TO - 1)),
                $urandom, 1'($urandom), int'($urandom_range(0, 3)));
   endfunction

   // Called at a falling edge: drive inputs from the model, check outputs, advance one clock.
   task automatic cycle();
      bit in_resp, in_setup, in_access, final_acc, exp_rd;
      logic [DW-1:0] exp_rsp;
      in_resp   = busy && (cyc >= resp_cyc);
      in_setup  = busy && (cyc == pop_cyc + 1);
      in_access = busy && (cyc >= pop_cyc + 2) && !in_resp;
      final_acc = in_access && !cur.stuck && (cyc == pop_cyc + 2 + cur.waits);
      rsp_ready = in_resp ? (hold_left == 0) : 1'($urandom);
      pready    = in_access ? final_acc : 1'($urandom);
      prdata    = final_acc ? cur.rdata : $urandom;
      pslverr   = final_acc ? cur.err : 1'($urandom);
      exp_rd    = !fifo_empty && (!busy || (in_resp && rsp_ready));
      #1;
      check("ctrl", {psel, penable, rsp_valid, fifo_rd_en},
            {in_setup || in_access, in_access, in_resp, exp_rd});
      if (in_setup || in_access)
         check("apb_cmd", {pwrite, paddr, pwdata}, {cur.wr, cur.addr, cur.wdata});
      if (in_resp) begin
         exp_rsp = (cur.wr || cur.stuck) ? '0 : cur.rdata;
         check("rsp", {rsp_err, rsp_rdata}, {cur.stuck | cur.err, exp_rsp});
      end
      if (busy && rsp_valid && first_valid < 0) first_valid = cyc;
      rd_log.push_back(fifo_rd_en);
      psel_log.push_back(psel);
      if (in_resp && rsp_ready) begin
         busy      = 1'b0;
         got_rdata = rsp_rdata;
         got_err   = rsp_err;
         got_lat   = (first_valid < 0) ? -1 : first_valid - pop_cyc;
      end else if (in_resp && hold_left > 0) begin
         hold_left--;
      end
      if (exp_rd) begin
         cur         = fifo_q.pop_front();
         busy        = 1'b1;
         pop_cyc     = cyc;
         hold_left   = cur.hold;
         first_valid = -1;
`ifdef APB_MASTER_TIMEOUT_EN
         resp_cyc = cur.stuck ? cyc + 2 + TO : cyc + 3 + cur.waits;
`else
         resp_cyc = cur.stuck ? 32'h3fff_ffff : cyc + 3 + cur.waits;
`endif
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      refresh_fifo();
   endtask

   task automatic run_idle(input int budget);
      int n = 0;
      while ((busy || fifo_q.size() != 0) && n < budget) begin
         cycle();
         n++;
      end
      check("drain", {busy, 1'(fifo_q.size() != 0)}, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[4];
      txn_t t;
      int   base, sum, sent, n;

      // Reset state, with an entry offered so a premature pop would show.
      fifo_empty = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("reset_state", {psel, penable, pwrite, rsp_valid, rsp_err, fifo_rd_en, paddr, pwdata, rsp_rdata}, 0);
      refresh_fifo();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) cycle();

      vecs[0].t = mk(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'hFFFF_FFFF, 1'b0, 0);
      vecs[0].exp_rdata = 32'h0; vecs[0].exp_err = 1'b0; vecs[0].exp_lat = 3;
      vecs[1].t = mk(1'b0, 32'h0000_0024, 32'h0, 3, 32'h1234_5678, 1'b1, 0);
      vecs[1].exp_rdata = 32'h1234_5678; vecs[1].exp_err = 1'b1; vecs[1].exp_lat = 6;
      vecs[2].t = mk(1'b1, 32'h8000_0004, 32'h5555_AAAA, 1, 32'hCAFE_F00D, 1'b1, 2);
      vecs[2].exp_rdata = 32'h0; vecs[2].exp_err = 1'b1; vecs[2].exp_lat = 4;
      vecs[3].t = mk(1'b0, 32'hFFFF_FFFC, 32'h0, 0, 32'hA5A5_0F0F, 1'b0, 1);
      vecs[3].exp_rdata = 32'hA5A5_0F0F; vecs[3].exp_err = 1'b0; vecs[3].exp_lat = 3;

      for (int i = 0; i < 4; i++) begin
         fifo_q.push_back(vecs[i].t);
         refresh_fifo();
         run_idle(100);
         check("vec_rdata", got_rdata, vecs[i].exp_rdata);
         check("vec_err", got_err, vecs[i].exp_err);
         check("vec_latency", got_lat, vecs[i].exp_lat);
      end

      // Back-to-back: three writes, zero waits, immediate acceptance.
      for (int i = 0; i < 3; i++) begin
         t = rand_txn();
         t.wr = 1'b1; t.waits = 0; t.hold = 0;
         fifo_q.push_back(t);
      end
      refresh_fifo();
      base = rd_log.size();
      repeat (12) cycle();
      for (int k = 0; k < 12; k++) begin
         check("b2b_rd_en", rd_log[base+k], (k == 0 || k == 3 || k == 6));
         if (k >= 1) check("b2b_psel", psel_log[base+k], !(k == 3 || k == 6 || k >= 9));
      end

      // Response backpressure with a second entry waiting.
      fifo_q.push_back(mk(1'b0, 32'h40, 32'h0, 0, 32'h0BAD_F00D, 1'b0, 5));
      fifo_q.push_back(mk(1'b1, 32'h44, 32'h7777_1111, 0, 32'h0, 1'b0, 0));
      refresh_fifo();
      base = rd_log.size();
      run_idle(100);
      sum = 0;
      for (int k = 1; k < 8; k++) sum += int'(rd_log[base+k]);
      check("bp_no_early_pop", sum, 0);
      check("bp_pop_at_ready", rd_log[base+8], 1'b1);

      // Randomized traffic with irregular arrivals.
      sent = 0;
      n = 0;
      while ((sent < 150 || busy || fifo_q.size() != 0) && n < 20000) begin
         if (sent < 150 && $urandom_range(0, 2) == 0) begin
            fifo_q.push_back(rand_txn());
            sent++;
            refresh_fifo();
         end
         cycle();
         n++;
      end
      check("random_drain", {busy, 1'(fifo_q.size() != 0), 1'(sent == 150)}, 3'b001);

      // Slave never ready.
      t = rand_txn();
      t.stuck = 1'b1;
      fifo_q.push_back(t);
      refresh_fifo();
`ifdef APB_MASTER_TIMEOUT_EN
      run_idle(50);
      check("timeout_err", got_err, 1'b1);
      check("timeout_rdata", got_rdata, 0);
      check("timeout_latency", got_lat, 2 + TO);
      fifo_q.push_back(mk(1'b0, 32'h80, 32'h0, 3, 32'h1, 1'b0, 0));
      refresh_fifo();
      repeat (3) cycle();
`else
      repeat (103) cycle();
      check("no_timeout_hold", {psel, penable, rsp_valid}, 3'b110);
`endif

      // Asynchronous reset between edges while in ACCESS.
      check("pre_reset_access", {psel, penable}, 2'b11);
      #3 rst_n = 1'b0;
      #1;
      check("reset_async", {psel, penable, rsp_valid, fifo_rd_en}, 0);
      busy = 1'b0;
      fifo_q.delete();
      refresh_fifo();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) cycle();
      check("post_reset_idle", {psel, rsp_valid}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
